// File: rtl/spi_bus_arb.sv
// Two-requester round-robin SPI mode-0 master; 8-bit transfers. Optional SPI_BUS_ARB_LOOPBACK_EN adds loopback_i (rx samples mosi).
// Latency: req_i to done_o pulse = 3+17*CLK_DIV cycles; CSn low for 1+17*CLK_DIV cycles.
// Backpressure: requests are level-sampled in IDLE only; a granted transfer always runs to completion.
`timescale 1ns/1ps
module spi_bus_arb #(
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 3
) (
    input  logic              clk100,
    input  logic              rstn,
    input  logic [1:0]        req_i,
    input  logic [1:0]        cs_sel0_i,
    input  logic [1:0]        cs_sel1_i,
    input  logic [7:0]        tx0_i,
    input  logic [7:0]        tx1_i,
    output logic [1:0]        gnt_o,
    output logic [1:0]        done_o,
    output logic [7:0]        rx_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              mosi_o,
    output logic [NUM_CS-1:0] csn_o,
`ifdef SPI_BUS_ARB_LOOPBACK_EN
    input  logic              loopback_i,
`endif
    input  logic              miso_i
);

    typedef enum logic [2:0] {IDLE, GRANT, SETUP, SHIFT, DONE, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t            state;
    logic [7:0]        div_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        tx_sh;
    logic [7:0]        rx_sh;
    logic              last_gnt;
    logic              bad_cs;

    logic              win;
    logic [1:0]        win_cs;
    logic [7:0]        win_tx;
    logic              win_bad;
    logic [NUM_CS-1:0] cs_mask;
    logic              sample_bit;

    // With both requesting, the one not served last wins.
    always_comb begin
        win     = (req_i == 2'b11) ? ~last_gnt : req_i[1];
        win_cs  = win ? cs_sel1_i : cs_sel0_i;
        win_tx  = win ? tx1_i : tx0_i;
        win_bad = (int'(win_cs) >= NUM_CS);
        cs_mask = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(win_cs) == i) cs_mask[i] = 1'b1;
        end
    end

`ifdef SPI_BUS_ARB_LOOPBACK_EN
    assign sample_bit = loopback_i ? mosi_o : miso_i;
`else
    assign sample_bit = miso_i;
`endif

    always_ff @(posedge clk100 or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 8'd0;
            last_gnt <= 1'b1;
            bad_cs   <= 1'b0;
            gnt_o    <= 2'b00;
            done_o   <= 2'b00;
            rx_o     <= 8'h00;
            busy_o   <= 1'b0;
            sclk_o   <= 1'b0;
            mosi_o   <= 1'b0;
            csn_o    <= '1;
        end else begin
            done_o <= 2'b00;
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        state    <= GRANT;
                        busy_o   <= 1'b1;
                        gnt_o    <= win ? 2'b10 : 2'b01;
                        last_gnt <= win;
                        bad_cs   <= win_bad;
                        tx_sh    <= win_tx;
                        if (!win_bad) begin
                            csn_o  <= ~cs_mask;
                            mosi_o <= win_tx[7];
                        end
                    end
                end
                GRANT: begin
                    div_cnt <= 8'd0;
                    state   <= bad_cs ? DONE : SETUP;
                end
                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        state   <= SHIFT;
                        div_cnt <= 8'd0;
                        bit_cnt <= 3'd0;
                        sclk_o  <= 1'b1;
                        rx_sh   <= {rx_sh[6:0], sample_bit};
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= 8'd0;
                        if (sclk_o) begin
                            sclk_o <= 1'b0;
                            tx_sh  <= {tx_sh[6:0], 1'b0};
                            mosi_o <= tx_sh[6];
                        end else if (bit_cnt == 3'd7) begin
                            // Low half of the last bit doubles as CSn hold time.
                            state <= DONE;
                            csn_o <= '1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            sclk_o  <= 1'b1;
                            rx_sh   <= {rx_sh[6:0], sample_bit};
                        end
                    end
                end
                DONE: begin
                    done_o  <= gnt_o;
                    rx_o    <= bad_cs ? 8'hFF : rx_sh;
                    gnt_o   <= 2'b00;
                    div_cnt <= 8'd0;
                    state   <= GAP;
                end
                GAP: begin
                    if (div_cnt == DIV_LAST) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arb.sv
// Directed bench for spi_bus_arb at CLK_DIV=4, NUM_CS=3 with a mode-0 slave model.
`timescale 1ns/1ps
module tb_spi_bus_arb;

    logic       clk100;
    logic       rstn;
    logic [1:0] req_i;
    logic [1:0] cs_sel0_i, cs_sel1_i;
    logic [7:0] tx0_i, tx1_i;
    logic [1:0] gnt_o, done_o;
    logic [7:0] rx_o;
    logic       busy_o, sclk_o, mosi_o;
    logic [2:0] csn_o;
    logic       miso_i;
    logic       loopback_i;

    int n_checks = 0;
    int n_errors = 0;

    spi_bus_arb #(.CLK_DIV(4), .NUM_CS(3)) dut (
        .clk100    (clk100),
        .rstn      (rstn),
        .req_i     (req_i),
        .cs_sel0_i (cs_sel0_i),
        .cs_sel1_i (cs_sel1_i),
        .tx0_i     (tx0_i),
        .tx1_i     (tx1_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .rx_o      (rx_o),
        .busy_o    (busy_o),
        .sclk_o    (sclk_o),
        .mosi_o    (mosi_o),
        .csn_o     (csn_o),
`ifdef SPI_BUS_ARB_LOOPBACK_EN
        .loopback_i(loopback_i),
`endif
        .miso_i    (miso_i)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    // Mode-0 slave: bit index advances on each SCLK fall, restarts on deselect.
    logic [7:0] slave_byte;
    logic       miso_force0;
    int         s_idx = 0;
    wire        csn_all_hi = &csn_o;
    always @(negedge sclk_o or posedge csn_all_hi) begin
        if (csn_all_hi) s_idx = 0;
        else            s_idx = s_idx + 1;
    end
    assign miso_i = (miso_force0 || s_idx > 7) ? 1'b0 : slave_byte[3'(7 - s_idx)];

    logic [7:0] mosi_cap = 8'h00;
    int         rise_cnt = 0;
    int         csn_low_cnt = 0;
    logic [2:0] csn_seen = 3'b111;
    logic [1:0] gnt_last = 2'b00;
    always @(posedge sclk_o) begin
        mosi_cap = {mosi_cap[6:0], mosi_o};
        rise_cnt = rise_cnt + 1;
    end
    always @(negedge clk100) begin
        if (csn_o != 3'b111) begin
            csn_low_cnt = csn_low_cnt + 1;
            csn_seen    = csn_o;
        end
        if (gnt_o != 2'b00) gnt_last = gnt_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts negedges from the caller's negedge until done_o is seen.
    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk100);
            cyc++;
        end while (done_o == 2'b00 && cyc < limit);
        check("done_seen", 32'(done_o != 2'b00), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int c = 0;
        while (busy_o && c < limit) begin
            @(negedge clk100);
            c++;
        end
        check("idle_reached", 32'(busy_o), 32'd0);
    endtask

    int cyc, rise0, low0, ndone;
    logic [7:0] exp_lb;
    logic [1:0] exp_g;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; req_i = 2'b00; cs_sel0_i = 2'd0; cs_sel1_i = 2'd0;
        tx0_i = 8'h00; tx1_i = 8'h00; slave_byte = 8'h00; miso_force0 = 1'b0; loopback_i = 1'b0;
        repeat (3) @(negedge clk100);
        check("rst_gnt",  32'(gnt_o),  32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_rx",   32'(rx_o),   32'h00);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_sclk", 32'(sclk_o), 32'd0);
        check("rst_mosi", 32'(mosi_o), 32'd0);
        check("rst_csn",  32'(csn_o),  32'b111);
        rstn = 1'b1;
        repeat (2) @(negedge clk100);

        // Basic transfer: A5 out, 3C in, CS0.
        tx0_i = 8'hA5; cs_sel0_i = 2'd0; slave_byte = 8'h3C;
        rise0 = rise_cnt; low0 = csn_low_cnt;
        req_i = 2'b01;
        @(negedge clk100);
        check("t1_gnt", 32'(gnt_o), 32'b01);
        check("t1_busy", 32'(busy_o), 32'd1);
        req_i = 2'b00;
        tx0_i = 8'h00; cs_sel0_i = 2'd1;
        wait_done(300, cyc);
        check("t1_latency", 32'(cyc + 1), 32'd71);
        check("t1_done", 32'(done_o), 32'b01);
        check("t1_rx", 32'(rx_o), 32'h3C);
        check("t1_gnt_clr", 32'(gnt_o), 32'd0);
        check("t1_mosi", 32'(mosi_cap), 32'hA5);
        check("t1_rises", 32'(rise_cnt - rise0), 32'd8);
        check("t1_csn_len", 32'(csn_low_cnt - low0), 32'd69);
        check("t1_csn_val", 32'(csn_seen), 32'b110);
        @(negedge clk100);
        check("t1_done_pulse", 32'(done_o), 32'd0);
        check("t1_rx_hold", 32'(rx_o), 32'h3C);
        wait_idle(50);
        @(negedge clk100);

        // Out-of-range chip select: no bus activity, rx=FF.
        tx0_i = 8'h77; cs_sel0_i = 2'd3;
        rise0 = rise_cnt; low0 = csn_low_cnt;
        req_i = 2'b01;
        @(negedge clk100);
        check("bad_gnt", 32'(gnt_o), 32'b01);
        req_i = 2'b00;
        wait_done(50, cyc);
        check("bad_latency", 32'(cyc), 32'd2);
        check("bad_done", 32'(done_o), 32'b01);
        check("bad_rx", 32'(rx_o), 32'hFF);
        check("bad_rises", 32'(rise_cnt - rise0), 32'd0);
        check("bad_csn_len", 32'(csn_low_cnt - low0), 32'd0);
        wait_idle(50);
        @(negedge clk100);

        // Loopback (only effective when the feature is built in); MISO held 0.
`ifdef SPI_BUS_ARB_LOOPBACK_EN
        exp_lb = 8'h5A;
`else
        exp_lb = 8'h00;
`endif
        miso_force0 = 1'b1; loopback_i = 1'b1;
        tx0_i = 8'h5A; cs_sel0_i = 2'd1;
        req_i = 2'b01;
        @(negedge clk100);
        req_i = 2'b00;
        wait_done(300, cyc);
        check("lb_rx", 32'(rx_o), 32'(exp_lb));
        check("lb_csn_val", 32'(csn_seen), 32'b101);
        check("lb_mosi", 32'(mosi_cap), 32'h5A);
        wait_idle(50);
        miso_force0 = 1'b0; loopback_i = 1'b0;
        @(negedge clk100);

        // Reset in the 4th bit of a requester-0 transfer.
        tx0_i = 8'hC3; cs_sel0_i = 2'd0; slave_byte = 8'h81;
        rise0 = rise_cnt;
        req_i = 2'b01;
        @(negedge clk100);
        req_i = 2'b00;
        cyc = 0;
        while (rise_cnt - rise0 < 4 && cyc < 200) begin
            @(negedge clk100);
            cyc++;
        end
        check("rst_mid_reached", 32'(rise_cnt - rise0), 32'd4);
        rstn = 1'b0;
        #1;
        check("rst_mid_csn", 32'(csn_o), 32'b111);
        check("rst_mid_sclk", 32'(sclk_o), 32'd0);
        check("rst_mid_gnt", 32'(gnt_o), 32'd0);
        check("rst_mid_busy", 32'(busy_o), 32'd0);
        check("rst_mid_rx", 32'(rx_o), 32'h00);
        ndone = 0;
        repeat (2) begin
            @(negedge clk100);
            if (done_o != 2'b00) ndone++;
        end
        rstn = 1'b1;
        repeat (60) begin
            @(negedge clk100);
            if (done_o != 2'b00) ndone++;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);

        // Continuous dual requests alternate, starting with requester 0.
        tx0_i = 8'h11; tx1_i = 8'h22; cs_sel0_i = 2'd0; cs_sel1_i = 2'd2; slave_byte = 8'h96;
        req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            low0 = csn_low_cnt;
            wait_done(300, cyc);
            check($sformatf("dual%0d_done", i), 32'(done_o), 32'(exp_g));
            check($sformatf("dual%0d_gnt", i), 32'(gnt_last), 32'(exp_g));
            check($sformatf("dual%0d_mosi", i), 32'(mosi_cap), (i % 2 == 0) ? 32'h11 : 32'h22);
            check($sformatf("dual%0d_csn", i), 32'(csn_seen), (i % 2 == 0) ? 32'b110 : 32'b011);
            check($sformatf("dual%0d_csn_len", i), 32'(csn_low_cnt - low0), 32'd69);
            check($sformatf("dual%0d_rx", i), 32'(rx_o), 32'h96);
        end
        req_i = 2'b00;
        wait_idle(50);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_bus_arb.md
Name: spi_bus_arb

Overview:
- PL-side SPI master engine shared between two on-chip requesters through a round-robin arbiter.
- Sequences complete 8-bit transfers: chip-select assertion, SCLK generation, MOSI shifting and MISO capture.
- Drives the same SCLK/CSn/MOSI/MISO bus as the PS SPI master. It is used when PL logic must access the SPI slaves (spi/spi2 targets) without PS involvement.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk100 cycles; legal range 1..255.
- NUM_CS, 3: number of active-low chip selects.

Ports:
- clk100  in  1  system clock.
- rstn  in  1  reset. Asynchronous assertion, active-low.
- req_i  in  2  transfer request per requester (bit0 = requester 0); level, sampled in IDLE only.
- cs_sel0_i  in  2  chip-select index for requester 0.
- cs_sel1_i  in  2  chip-select index for requester 1.
- tx0_i  in  8  transmit byte, requester 0.
- tx1_i  in  8  transmit byte, requester 1.
- gnt_o  out  2  one-hot grant; held for the whole transfer.
- done_o  out  2  one-cycle completion pulse to the granted requester.
- rx_o  out  8  received byte; valid in the done_o cycle and held until the next done_o.
- busy_o  out  1  high whenever state != IDLE.
- sclk_o  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- mosi_o  out  1  SPI data out, MSB first.
- csn_o  out  NUM_CS  active-low chip selects.
- miso_i  in  1  SPI data in.

Behaviour:
- Reset values:
  - gnt_o=0, done_o=0, rx_o=8'h00, busy_o=0.
  - sclk_o=0, mosi_o=0, csn_o=all 1s.
  - Round-robin pointer favours requester 0.
- FSM states: IDLE -> GRANT -> SETUP -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE:
  - Any req_i bit set -> winner chosen.
  - Both set -> the requester not granted last wins. The pointer updates on each grant.
  - Winner's tx byte and cs_sel are latched. Next state is GRANT.
- GRANT (1 cycle):
  - gnt_o asserted.
  - If latched cs_sel >= NUM_CS -> go to DONE with rx=8'hFF. No bus activity: csn stays all high, sclk stays low.
  - Otherwise, csn_o[cs_sel] is driven low and mosi_o = bit7.
- SETUP: CLK_DIV cycles with sclk low (CSn-to-first-edge setup).
- SHIFT: 8 bits, each 2*CLK_DIV cycles.
  - sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - miso_i is sampled into the shift register at the clk100 cycle in which sclk_o rises (registered edge).
  - mosi_o updates to the next bit when sclk_o falls.
  - After the 8th falling edge, csn_o returns to all high.
- DONE (1 cycle): done_o[granted]=1, rx_o updated, gnt_o cleared in the same cycle.
- GAP: CLK_DIV cycles with csn high (minimum deselect time). Then IDLE.
- Timing totals:
  - csn low for exactly 1+17*CLK_DIV cycles; 69 cycles at CLK_DIV=4.
  - req_i-to-done_o latency = 3+17*CLK_DIV cycles.
- req_i deassertion mid-transfer is ignored; the transfer completes and done_o still pulses.
- req_i held high: a new transfer follows after GAP. Continuous dual requests alternate 0,1,0,1.
- Changes to tx/cs_sel inputs after the IDLE latch have no effect on the current transfer.
- Reset mid-transfer: outputs return to reset values asynchronously; no done_o is generated.
- CLK_DIV counter is 8 bits; the bit counter is 3 bits with terminal count 7.

Optional Feature:
- Macro: SPI_BUS_ARB_LOOPBACK_EN.
- Defined: adds input loopback_i (1 bit). When loopback_i=1, the shift register samples mosi_o instead of miso_i, so rx equals tx for every transfer. Bus outputs are unchanged.
- Undefined: port absent; miso_i is always sampled.

Test Plan:
- CLK_DIV=4, req_i=01, tx0=0xA5, cs_sel0=0, slave returns 0x3C:
  - MOSI shows A5 MSB first on 8 rising edges.
  - csn_o=3'b110 for 69 cycles.
  - done_o=01 with rx_o=0x3C, 71 cycles after req.
- req_i=11 held for four transfers, tx0=0x11, tx1=0x22:
  - Grants alternate 01,10,01,10.
  - MOSI bytes 11,22,11,22.
  - Requester 1 uses cs_sel1=2 -> csn_o=3'b011 during its transfers.
- req_i=01 with cs_sel0=3:
  - No sclk toggle, csn stays 3'b111.
  - done_o=01 two cycles after the grant, rx_o=0xFF.
- rstn pulsed low during the 4th bit of a transfer:
  - csn_o=111, sclk_o=0, gnt_o=0 immediately.
  - No done_o.
  - The next req_i=11 grants requester 0.
- With SPI_BUS_ARB_LOOPBACK_EN and loopback_i=1, tx0=0x5A, miso_i tied 0 -> rx_o=0x5A. Without the macro, the same stimulus gives rx_o=0x00.
